// File: rtl/eight_bit_addsub_arbiter.sv
// Two-requester round-robin front end sharing one 8-bit add/sub datapath.
// Each operation runs IDLE (accept) -> EXEC (compute) -> RESP (hold result until taken).
module eight_bit_addsub_arbiter #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [DATA_W-1:0] a_data0,
  input  logic [DATA_W-1:0] a_data1,
  input  logic              a_mode,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [DATA_W-1:0] b_data0,
  input  logic [DATA_W-1:0] b_data1,
  input  logic              b_mode,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_sum,
  output logic              rsp_carry,
  output logic              rsp_overflow,
  output logic [15:0]       op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  // Returns {overflow, carry, sum}; subtract is d0 + ~d1 + 1.
  function automatic logic [DATA_W+1:0] addsub(input logic [DATA_W-1:0] d0,
                                               input logic [DATA_W-1:0] d1,
                                               input logic              mode);
    logic [DATA_W-1:0] eff1;
    logic [DATA_W:0]   res;
    logic              ovf;
    eff1 = mode ? d1 : ~d1;
    res  = {1'b0, d0} + {1'b0, eff1} + {{DATA_W{1'b0}}, ~mode};
    ovf  = (d0[DATA_W-1] == eff1[DATA_W-1]) && (res[DATA_W-1] != d0[DATA_W-1]);
    return {ovf, res};
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t              state_q;
  logic                last_b_q;
  logic                op_id_q;
  logic                op_mode_q;
  logic [DATA_W-1:0]   op_d0_q;
  logic [DATA_W-1:0]   op_d1_q;
  logic                rsp_id_q;
  logic [DATA_W-1:0]   rsp_sum_q;
  logic                rsp_carry_q;
  logic                rsp_ovf_q;
  logic [15:0]         op_count_q;
  logic [15:0]         op_count_d;
  logic [DATA_W+1:0]   alu_d;
  logic                grant_a;
  logic                grant_b;
  logic                accept;

  // last_b_q = 1 means B was served last, so A wins a tie; reset leaves A first.
  always_comb begin
    grant_a    = a_valid && (!b_valid || last_b_q);
    grant_b    = b_valid && !grant_a;
    accept     = (state_q == IDLE) && !reset && (a_valid || b_valid);
    a_ready    = accept && grant_a;
    b_ready    = accept && grant_b;
    alu_d      = addsub(op_d0_q, op_d1_q, op_mode_q);
    op_count_d = sat_inc(op_count_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      last_b_q    <= 1'b1;
      rsp_id_q    <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_carry_q <= 1'b0;
      rsp_ovf_q   <= 1'b0;
      op_count_q  <= 16'h0000;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q  <= EXEC;
            last_b_q <= grant_b;
          end
        end
        EXEC: begin
          rsp_id_q    <= op_id_q;
          rsp_sum_q   <= alu_d[DATA_W-1:0];
          rsp_carry_q <= alu_d[DATA_W];
          rsp_ovf_q   <= alu_d[DATA_W+1];
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            state_q    <= IDLE;
            op_count_q <= op_count_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Operand capture: loaded only on the accepting edge, so later input changes are ignored.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_id_q   <= grant_b;
      op_mode_q <= grant_a ? a_mode  : b_mode;
      op_d0_q   <= grant_a ? a_data0 : b_data0;
      op_d1_q   <= grant_a ? a_data1 : b_data1;
    end
  end

  assign rsp_valid    = (state_q == RESP);
  assign rsp_id       = rsp_id_q;
  assign rsp_sum      = rsp_sum_q;
  assign rsp_carry    = rsp_carry_q;
  assign rsp_overflow = rsp_ovf_q;
  assign op_count     = op_count_q;

endmodule

// File: tb/tb_eight_bit_addsub_arbiter.sv
// Directed bench for eight_bit_addsub_arbiter: vector table plus hand-written corner sequences.
module tb_eight_bit_addsub_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic        a_ready, b_ready;
  logic [7:0]  a_data0 = '0, a_data1 = '0, b_data0 = '0, b_data1 = '0;
  logic        a_mode = 1'b0, b_mode = 1'b0;
  logic        rsp_valid, rsp_id, rsp_carry, rsp_overflow;
  logic        rsp_ready = 1'b1;
  logic [7:0]  rsp_sum;
  logic [15:0] op_count;

  int n_vec = 0;
  int n_err = 0;
  int ids[$];
  int acc_cyc[$];

  typedef struct {
    logic       av;
    logic [7:0] a0, a1;
    logic       am;
    logic       bv;
    logic [7:0] b0, b1;
    logic       bm;
    logic       id;
    logic [7:0] sum;
    logic       c;
    logic       ov;
  } vec_t;

  vec_t tbl[8];

  eight_bit_addsub_arbiter dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_data0(a_data0), .a_data1(a_data1), .a_mode(a_mode),
    .b_valid(b_valid), .b_ready(b_ready), .b_data0(b_data0), .b_data1(b_data1), .b_mode(b_mode),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
    .rsp_carry(rsp_carry), .rsp_overflow(rsp_overflow), .op_count(op_count)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input logic [15:0] exp_cnt);
    int waited;
    waited = 0;
    @(negedge clk);
    a_valid = v.av; a_data0 = v.a0; a_data1 = v.a1; a_mode = v.am;
    b_valid = v.bv; b_data0 = v.b0; b_data1 = v.b1; b_mode = v.bm;
    rsp_ready = 1'b1;
    #1;
    while (!(a_ready || b_ready) && waited < 10) begin
      @(negedge clk); #1; waited++;
    end
    check("accept_seen", 32'(a_ready || b_ready), 1);
    check("one_ready", 32'(a_ready & b_ready), 0);
    check("grant_id", 32'(b_ready), 32'(v.id));
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;
    #1;
    check("exec_rsp_valid", 32'(rsp_valid), 0);
    @(negedge clk); #1;
    check("rsp_valid", 32'(rsp_valid), 1);
    check("rsp_id", 32'(rsp_id), 32'(v.id));
    check("rsp_sum", 32'(rsp_sum), 32'(v.sum));
    check("rsp_carry", 32'(rsp_carry), 32'(v.c));
    check("rsp_overflow", 32'(rsp_overflow), 32'(v.ov));
    @(negedge clk); #1;
    check("rsp_valid_after", 32'(rsp_valid), 0);
    check("op_count", 32'(op_count), 32'(exp_cnt));
  endtask

  initial begin
    //        av a0     a1     am bv b0     b1     bm id sum    c  ov
    tbl[0] = '{1, 8'h7F, 8'h01, 1, 0, 8'h00, 8'h00, 0, 0, 8'h80, 0, 1};
    tbl[1] = '{0, 8'h00, 8'h00, 0, 1, 8'h05, 8'h07, 0, 1, 8'hFE, 0, 0};
    tbl[2] = '{0, 8'h00, 8'h00, 0, 1, 8'h07, 8'h05, 0, 1, 8'h02, 1, 0};
    tbl[3] = '{1, 8'h80, 8'h01, 0, 0, 8'h00, 8'h00, 0, 0, 8'h7F, 1, 1};
    tbl[4] = '{1, 8'hFF, 8'h01, 1, 1, 8'h10, 8'h20, 1, 1, 8'h30, 0, 0};
    tbl[5] = '{1, 8'hFF, 8'h01, 1, 1, 8'h10, 8'h20, 1, 0, 8'h00, 1, 0};
    tbl[6] = '{1, 8'h40, 8'h40, 1, 0, 8'h00, 8'h00, 0, 0, 8'h80, 0, 1};
    tbl[7] = '{0, 8'h00, 8'h00, 0, 1, 8'h00, 8'h00, 0, 1, 8'h00, 1, 0};

    // Reset state, with requests pending to show ready is held low.
    a_valid = 1'b1; b_valid = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    check("rst_a_ready", 32'(a_ready), 0);
    check("rst_b_ready", 32'(b_ready), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_id", 32'(rsp_id), 0);
    check("rst_rsp_sum", 32'(rsp_sum), 0);
    check("rst_rsp_carry", 32'(rsp_carry), 0);
    check("rst_rsp_overflow", 32'(rsp_overflow), 0);
    check("rst_op_count", 32'(op_count), 0);
    @(negedge clk);
    reset = 1'b0; a_valid = 1'b0; b_valid = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(tbl[i], 16'(i + 1));

    // Contention: both requesters valid continuously from reset.
    do_reset();
    a_valid = 1'b1; b_valid = 1'b1; rsp_ready = 1'b1;
    a_data0 = 8'h01; a_data1 = 8'h02; a_mode = 1'b1;
    b_data0 = 8'h09; b_data1 = 8'h03; b_mode = 1'b0;
    begin
      int resp;
      int cyc;
      resp = 0; cyc = 0;
      while (resp < 4 && cyc < 40) begin
        #1;
        if (a_ready || b_ready) begin
          check("cont_one_ready", 32'(a_ready & b_ready), 0);
          ids.push_back(int'(b_ready));
          acc_cyc.push_back(cyc);
        end
        if (rsp_valid && rsp_ready) resp++;
        @(negedge clk);
        cyc++;
      end
    end
    a_valid = 1'b0; b_valid = 1'b0;
    #1;
    check("cont_accepts", 32'(ids.size() >= 4), 1);
    for (int i = 0; i < 4; i++)
      check("cont_order", (i < ids.size()) ? 32'(ids[i]) : 32'd2, 32'(i % 2));
    for (int i = 1; i < 4; i++)
      check("cont_spacing", (i < acc_cyc.size()) ? 32'(acc_cyc[i] - acc_cyc[i-1]) : 32'd0, 3);
    check("cont_op_count", 32'(op_count), 4);

    // Backpressure: result must hold while operands on the inputs churn.
    @(negedge clk);
    a_valid = 1'b1; a_data0 = 8'h80; a_data1 = 8'h01; a_mode = 1'b0; rsp_ready = 1'b0;
    #1;
    check("bp_accept", 32'(a_ready), 1);
    @(negedge clk);
    a_valid = 1'b0;
    begin
      int waited;
      waited = 0;
      #1;
      while (!rsp_valid && waited < 10) begin
        @(negedge clk); #1; waited++;
      end
    end
    for (int i = 0; i < 5; i++) begin
      a_valid = 1'b1; b_valid = 1'b1;
      a_data0 = 8'(i * 37); a_data1 = 8'(i + 5); a_mode = i[0];
      b_data0 = 8'(i * 11); b_data1 = 8'(255 - i); b_mode = ~i[0];
      #1;
      check("bp_rsp_valid", 32'(rsp_valid), 1);
      check("bp_rsp_id", 32'(rsp_id), 0);
      check("bp_rsp_sum", 32'(rsp_sum), 32'h7F);
      check("bp_rsp_carry", 32'(rsp_carry), 1);
      check("bp_rsp_overflow", 32'(rsp_overflow), 1);
      check("bp_no_ready", 32'(a_ready | b_ready), 0);
      check("bp_op_count", 32'(op_count), 4);
      @(negedge clk);
    end
    rsp_ready = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk); #1;
    check("bp_done_count", 32'(op_count), 5);
    check("bp_done_valid", 32'(rsp_valid), 0);
    @(negedge clk); #1;
    check("bp_single_completion", 32'(op_count), 5);

    // Reset pulsed while the operation is in EXEC.
    do_reset();
    a_valid = 1'b1; a_data0 = 8'h11; a_data1 = 8'h22; a_mode = 1'b1;
    #1;
    check("mid_accept_a", 32'(a_ready), 1);
    @(negedge clk);
    a_valid = 1'b0;
    #1 reset = 1'b1;
    #2 reset = 1'b0;
    @(negedge clk); #1;
    check("mid_rsp_valid", 32'(rsp_valid), 0);
    check("mid_op_count", 32'(op_count), 0);
    a_valid = 1'b1; b_valid = 1'b1;
    #1;
    check("mid_grant_a", 32'(a_ready), 1);
    check("mid_no_grant_b", 32'(b_ready), 0);
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    check("mid_after_count", 32'(op_count), 1);

    // Saturation from 16'hFFFE.
    @(negedge clk);
    force dut.op_count_q = 16'hFFFE;
    #1 release dut.op_count_q;
    #1;
    check("sat_preload", 32'(op_count), 32'hFFFE);
    run_vec(tbl[0], 16'hFFFF);
    run_vec(tbl[0], 16'hFFFF);
    run_vec(tbl[0], 16'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
